// File: rtl/data_path_gen_pkg.sv
// rtl/data_path_gen_pkg.sv - shared opcodes and helpers for the data_path_gen datapath
// Contents: ALU opcode constants, shifter opcode constants, clog2 for parameter sizing.
package data_path_gen_pkg;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_NOT   = 3'd5;
  localparam logic [2:0] ALU_PASSB = 3'd6;
  localparam logic [2:0] ALU_ADC   = 3'd7;

  localparam logic [2:0] SH_NONE = 3'd0;
  localparam logic [2:0] SH_SL0  = 3'd1;
  localparam logic [2:0] SH_SR0  = 3'd2;
  localparam logic [2:0] SH_ROL  = 3'd3;
  localparam logic [2:0] SH_ROR  = 3'd4;
  localparam logic [2:0] SH_SL1  = 3'd5;
  localparam logic [2:0] SH_SR1  = 3'd6;
  localparam logic [2:0] SH_ASR  = 3'd7;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/data_path_gen_stack.sv
// rtl/data_path_gen_stack.sv - hardware return stack with full/empty and sticky error
// Ports: clk, rst (async active-low); push/pop requests; pc value to store;
//        top_next = top-of-stack + 1 (0 + 1 when empty); full, empty, err (sticky).
module data_path_gen_stack
  import data_path_gen_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] top_next,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam int IW = clog2(DEPTH);
  // One extra pointer bit so that 0..DEPTH are all representable.
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;
  logic [IW-1:0]     wr_idx;
  logic [IW-1:0]     top_idx;
  logic              do_write;
  logic              inc;
  logic              dec;
  logic              fault;

  assign empty   = (ptr == '0);
  assign full    = (ptr == DEPTH_P);
  assign top_idx = IW'(ptr - PW'(1));

  always_comb begin
    do_write = 1'b0;
    inc      = 1'b0;
    dec      = 1'b0;
    fault    = 1'b0;
    wr_idx   = ptr[IW-1:0];
    if (push && pop && !empty) begin
      // Simultaneous push/pop replaces the top entry in place.
      do_write = 1'b1;
      wr_idx   = top_idx;
    end else if (push) begin
      if (full) begin
        fault = 1'b1;
      end else begin
        do_write = 1'b1;
        inc      = 1'b1;
      end
    end else if (pop) begin
      if (empty) fault = 1'b1;
      else       dec   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
      err <= 1'b0;
    end else begin
      if (inc)   ptr <= ptr + PW'(1);
      if (dec)   ptr <= ptr - PW'(1);
      if (fault) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_idx] <= pc;
  end

  assign top_next = (empty ? '0 : mem[top_idx]) + ADDR_W'(1);

endmodule

// File: rtl/data_path_gen.sv
// rtl/data_path_gen.sv - parametrised core datapath: regfile, ALU, shifter, PC, return stack
// Ports: clk, rst (async active-low); data_in/kte/imm operands; regfile controls
//        insel/selk/selimm/we/raa/rab/wa; opalu, sh, ldflag; ldpc/selpc/ninst_addr;
//        wr_en/rd_en stack; irq_take/irq_vec/reti; outputs data_out, inst_addr,
//        stack_addr, zero_o, carry_o, stk_full, stk_empty, stk_err, irq_active.
// Build option: DATA_PATH_GEN_IRQ_EN enables interrupt entry/return with flag shadowing.
module data_path_gen
  import data_path_gen_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 11,
  parameter int NREG        = 8,
  parameter int STACK_DEPTH = 16,
  parameter int RESET_VEC   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [DATA_W-1:0]      kte,
  input  logic [DATA_W-1:0]      imm,
  input  logic                   insel,
  input  logic                   selk,
  input  logic                   selimm,
  input  logic                   we,
  input  logic [clog2(NREG)-1:0] raa,
  input  logic [clog2(NREG)-1:0] rab,
  input  logic [clog2(NREG)-1:0] wa,
  input  logic [2:0]             opalu,
  input  logic [2:0]             sh,
  input  logic                   ldflag,
  input  logic                   ldpc,
  input  logic                   selpc,
  input  logic [ADDR_W-1:0]      ninst_addr,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   irq_take,
  input  logic [ADDR_W-1:0]      irq_vec,
  input  logic                   reti,
  output logic [DATA_W-1:0]      data_out,
  output logic [ADDR_W-1:0]      inst_addr,
  output logic [ADDR_W-1:0]      stack_addr,
  output logic                   zero_o,
  output logic                   carry_o,
  output logic                   stk_full,
  output logic                   stk_empty,
  output logic                   stk_err,
  output logic                   irq_active
);

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] port_a, port_b, alu_b, alu_res, sh_res, wr_data;
  logic [DATA_W:0]   ext;
  logic              alu_z, alu_c;
  logic [ADDR_W-1:0] pc;
  logic              reti_ok, take_ok;
  logic [ADDR_W-1:0] restore_pc;
  logic              restore_z, restore_c;

  // Register file: combinational reads, so a same-cycle write is seen only after the edge.
  assign port_a = regs[raa];
  assign port_b = regs[rab];
  assign alu_b  = selimm ? imm : port_b;

  always_ff @(posedge clk) begin
    if (we) regs[wa] <= wr_data;
  end

  // ALU is one bit wider so carry/borrow fall out of the top bit.
  always_comb begin
    ext = '0;
    case (opalu)
      ALU_ADD:   ext = {1'b0, port_a} + {1'b0, alu_b};
      ALU_SUB:   ext = {1'b0, port_a} - {1'b0, alu_b};
      ALU_AND:   ext = {1'b0, port_a & alu_b};
      ALU_OR:    ext = {1'b0, port_a | alu_b};
      ALU_XOR:   ext = {1'b0, port_a ^ alu_b};
      ALU_NOT:   ext = {1'b0, ~port_a};
      ALU_PASSB: ext = {1'b0, alu_b};
      ALU_ADC:   ext = {1'b0, port_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, carry_o};
      default:   ext = '0;
    endcase
  end

  assign alu_res = ext[DATA_W-1:0];
  assign alu_c   = ext[DATA_W];
  assign alu_z   = (alu_res == '0);

  always_comb begin
    sh_res = alu_res;
    case (sh)
      SH_SL0:  sh_res = {alu_res[DATA_W-2:0], 1'b0};
      SH_SR0:  sh_res = {1'b0, alu_res[DATA_W-1:1]};
      SH_ROL:  sh_res = {alu_res[DATA_W-2:0], alu_res[DATA_W-1]};
      SH_ROR:  sh_res = {alu_res[0], alu_res[DATA_W-1:1]};
      SH_SL1:  sh_res = {alu_res[DATA_W-2:0], 1'b1};
      SH_SR1:  sh_res = {1'b1, alu_res[DATA_W-1:1]};
      SH_ASR:  sh_res = {alu_res[DATA_W-1], alu_res[DATA_W-1:1]};
      default: sh_res = alu_res;
    endcase
  end

  assign data_out = sh_res;
  assign wr_data  = insel ? sh_res : (selk ? kte : data_in);

`ifdef DATA_PATH_GEN_IRQ_EN
  logic              irq_q;
  logic [ADDR_W-1:0] shadow_pc;
  logic              shadow_z, shadow_c;

  // Entry and return are mutually exclusive by construction (gated on irq_q).
  assign reti_ok = reti & irq_q;
  assign take_ok = irq_take & ~irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q     <= 1'b0;
      shadow_pc <= '0;
      shadow_z  <= 1'b0;
      shadow_c  <= 1'b0;
    end else if (reti_ok) begin
      irq_q <= 1'b0;
    end else if (take_ok) begin
      irq_q     <= 1'b1;
      shadow_pc <= pc;
      shadow_z  <= zero_o;
      shadow_c  <= carry_o;
    end
  end

  assign restore_pc = shadow_pc;
  assign restore_z  = shadow_z;
  assign restore_c  = shadow_c;
  assign irq_active = irq_q;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_take, reti, irq_vec};
  assign reti_ok    = 1'b0;
  assign take_ok    = 1'b0;
  assign restore_pc = '0;
  assign restore_z  = 1'b0;
  assign restore_c  = 1'b0;
  assign irq_active = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= ADDR_W'(RESET_VEC);
    end else if (reti_ok) begin
      pc <= restore_pc;
    end else if (take_ok) begin
      pc <= irq_vec;
    end else if (ldpc) begin
      pc <= selpc ? ninst_addr : pc + ADDR_W'(1);
    end
  end

  // Interrupt entry swallows ldflag so the shadow sees the pre-interrupt flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_o  <= 1'b0;
      carry_o <= 1'b0;
    end else if (reti_ok) begin
      zero_o  <= restore_z;
      carry_o <= restore_c;
    end else if (ldflag && !take_ok) begin
      zero_o  <= alu_z;
      carry_o <= alu_c;
    end
  end

  assign inst_addr = pc;

  data_path_gen_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_en),
    .pop      (rd_en),
    .pc       (pc),
    .top_next (stack_addr),
    .full     (stk_full),
    .empty    (stk_empty),
    .err      (stk_err)
  );

endmodule

// File: doc/data_path_gen.md
Name: data_path_gen

Overview:
- Parametrised successor to the Natalius core datapath.
- Holds the register file, an ALU with flag generation, a post-ALU shifter, a program counter and a hardware return stack with overflow/underflow detection.
- Width, register count, address width and stack depth are parameters. Optional interrupt entry/return with flag shadowing.
- Driven cycle-by-cycle by the control unit; sits between instruction memory, data port and controller.

Parameters:
DATA_W, 8, datapath/register width (>=4)
ADDR_W, 11, program-counter and stack-entry width
NREG, 8, number of general registers (power of 2; RA_W = clog2(NREG))
STACK_DEPTH, 16, return-stack entries (power of 2, >=2)
RESET_VEC, 0, PC value after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
data_in  in  DATA_W  external data port value
kte  in  DATA_W  constant for register load
imm  in  DATA_W  ALU immediate operand
insel  in  1  regfile write source: 1=shifter out, 0=kte/data_in mux
selk  in  1  1=kte, 0=data_in
selimm  in  1  ALU B operand: 1=imm, 0=port B
we  in  1  register write enable
raa, rab, wa  in  RA_W  read A, read B, write address
opalu  in  3  ALU operation
sh  in  3  shift operation
ldflag  in  1  capture zero/carry
ldpc  in  1  PC update enable
selpc  in  1  1=load ninst_addr, 0=increment
ninst_addr  in  ADDR_W  jump target
wr_en, rd_en  in  1  stack push / pop
irq_take  in  1  enter interrupt (feature only)
irq_vec  in  ADDR_W  interrupt target (feature only)
reti  in  1  return from interrupt (feature only)
data_out  out  DATA_W  shifter output
inst_addr  out  ADDR_W  current PC
stack_addr  out  ADDR_W  top-of-stack + 1 (mod 2^ADDR_W)
zero_o, carry_o  out  1  registered flags
stk_full, stk_empty  out  1  stack occupancy status
stk_err  out  1  sticky over/underflow
irq_active  out  1  in interrupt (0 when feature compiled out)

Behaviour:
- Reset (rst=0, async): PC=RESET_VEC, flags=0, stack pointer=0, stk_err=0, irq_active=0.
  - Register file is not reset.
  - stk_empty=1, stk_full=0.
- Register file:
  - Port A/B reads are combinational.
  - Write is synchronous on we.
  - Read-during-write to the same address returns the old value.
- ALU (combinational), A=port A, B=selimm?imm:portB, DATA_W+1-bit arithmetic:
  - 0 ADD: carry=carry-out
  - 1 SUB (A-B): carry=borrow
  - 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 PASS B: carry=0
  - 7 ADC (A+B+carry_o): carry=carry-out
  - zero = (result==0).
- Shifter on ALU result:
  - 0 none, 1 SL fill0, 2 SR fill0, 3 ROL, 4 ROR, 5 SL fill1, 6 SR fill1, 7 ASR.
  - Flags come from the ALU, not the shifter.
- data_out = shifter output.
- Flags: on ldflag, zero_o/carry_o <= ALU zero/carry.
- PC:
  - ldpc&selpc -> ninst_addr; ldpc&!selpc -> PC+1, wraps 2^ADDR_W-1 -> 0.
  - Priority: reti > irq_take > ldpc.
- Stack:
  - Push (wr_en only) writes current PC at ptr, ptr+1.
  - Pop (rd_en only) ptr-1.
  - Top = entry[ptr-1], or 0 when empty; stack_addr = top+1 (combinational).
  - Push when full: no write, ptr held, stk_err<=1.
  - Pop when empty: ptr held, stk_err<=1.
  - wr_en&rd_en: top overwritten with PC, ptr unchanged; if empty, behaves as push.
  - stk_err clears only on reset.
- Flag ldflag and PC load in the same cycle are independent.

Optional Feature:
- Macro: DATA_PATH_GEN_IRQ_EN.
- Enabled:
  - irq_take with irq_active=0: shadow_pc<=PC, shadow flags<=zero_o/carry_o, PC<=irq_vec, irq_active<=1. ldflag in that cycle is ignored.
  - irq_take with irq_active=1 is ignored (no nesting).
  - reti with irq_active=1: PC<=shadow_pc, flags<=shadow, irq_active<=0. reti with irq_active=0 is ignored.
  - The stack is untouched by interrupt entry and return.
- Disabled: irq_take/irq_vec/reti are ignored, no shadow registers, irq_active tied 0.

Decomposition:
- Package data_path_gen_pkg: ALU opcode constants, shift opcode constants, clog2 function.
- Sub-module data_path_gen_stack: LIFO with ptr, full/empty and err.
- Register file, ALU and shifter stay inline.

Test Plan:
- Reset mid-run: drive rst=0 asynchronously -> PC=0, flags=0, stk_empty=1, stk_err=0 immediately, before the next clock edge.
- ALU/flags (DATA_W=8): r1=0xFF, imm=0x01, ADD, ldflag -> result 0x00, zero_o=1, carry_o=1. Then ADC 0x00+0x00 -> result 0x01.
- Shifter: ALU result 0x81 with sh=7 -> 0xC0; sh=3 -> 0x03; sh=2 -> 0x40.
- Stack (STACK_DEPTH=4):
  - Push at PC=0x10,0x20,0x30,0x40 -> stk_full=1, stack_addr=0x41.
  - Fifth push -> stk_err=1, contents unchanged.
  - Pop x4 -> stk_empty=1; a further pop keeps ptr at 0.
- PC: PC=0x7FF with ldpc&!selpc -> 0x000; ldpc&selpc with ninst_addr=0x123 -> 0x123.
- IRQ (macro defined): at PC=0x050 with zero_o=1, irq_take, irq_vec=0x3F0 -> PC=0x3F0, irq_active=1. Clear the flags, then reti -> PC=0x050, zero_o=1, irq_active=0.
